// File: rtl/pcreg.sv
// -----------------------------------------------------------------------------
// pcreg -- program-counter register with load history and load counter
//
// Holds the current program-counter value and updates it from data_in on
// every rising clock edge where ena is high. It also keeps the value that was
// replaced by the most recent accepted load, and counts accepted loads with a
// saturating 32-bit counter. Every output comes straight from a flop.
//
// Optional feature (compile-time macro PCREG_ALIGN_CHECK_EN):
//   Defined   : on each accepted load, misalign captures whether data_in is
//               not word aligned (data_in[1:0] != 0). data_out stores data_in
//               unmodified. misalign holds while ena=0 and clears on reset.
//   Undefined : misalign is tied to 0 and no alignment logic is built.
//
// Parameters:
//   WIDTH       data path width, 8..64 (default 32)
//   RESET_VALUE value placed on data_out and data_prev by reset (default 0)
//
// Ports:
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset (priority over ena)
//   ena        in   1      load enable
//   data_in    in   WIDTH  next program-counter value
//   data_out   out  WIDTH  current program-counter value
//   data_prev  out  WIDTH  data_out value before the most recent accepted load
//   load_cnt   out  32     accepted loads since reset, saturates at all-ones
//   misalign   out  1      alignment error flag (0 when feature compiled out)
// -----------------------------------------------------------------------------
module pcreg #(
  parameter int unsigned             WIDTH       = 32,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_prev,
  output logic [31:0]      load_cnt,
  output logic             misalign
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] data_out_d;
  logic [WIDTH-1:0] data_prev_q;
  logic [WIDTH-1:0] data_prev_d;
  logic [31:0]      load_cnt_q;
  logic [31:0]      load_cnt_d;

  // Next-state for the value, history and counter registers.
  always_comb begin
    data_out_d  = data_out_q;
    data_prev_d = data_prev_q;
    load_cnt_d  = load_cnt_q;
    if (ena) begin
      data_out_d  = data_in;
      data_prev_d = data_out_q;
      // A load equal to the current value still counts as a load.
      if (load_cnt_q == CNT_MAX) begin
        load_cnt_d = load_cnt_q;
      end else begin
        load_cnt_d = load_cnt_q + 32'd1;
      end
    end else begin
      data_out_d  = data_out_q;
      data_prev_d = data_prev_q;
      load_cnt_d  = load_cnt_q;
    end
  end

  // State registers; reset is synchronous and wins over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= RESET_VALUE;
      data_prev_q <= RESET_VALUE;
      load_cnt_q  <= 32'd0;
    end else begin
      data_out_q  <= data_out_d;
      data_prev_q <= data_prev_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign data_prev = data_prev_q;
  assign load_cnt  = load_cnt_q;

`ifdef PCREG_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  // Flag is refreshed only by an accepted load, otherwise it holds.
  always_comb begin
    misalign_d = misalign_q;
    if (ena) begin
      misalign_d = (data_in[1:0] != 2'b00);
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Alignment flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pcreg.sv
// -----------------------------------------------------------------------------
// tb_pcreg -- directed self-checking bench for pcreg (WIDTH=32, RESET_VALUE=0)
// Inputs change on the falling edge; outputs are sampled on the falling edge
// following the rising edge under test.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pcreg;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] data_prev;
  logic [31:0] load_cnt;
  logic        misalign;

  int n_checks;
  int n_fail;

  pcreg #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .data_in  (data_in),
    .data_out (data_out),
    .data_prev(data_prev),
    .load_cnt (load_cnt),
    .misalign (misalign)
  );

  // 20 ns clock period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; data_in = 32'h0000_000F;
    tick();
    n_checks++;
    if (data_out !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0);
    end
    n_checks++;
    if (data_prev !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_data_prev: got %h expected %h", data_prev, 32'h0);
    end
    n_checks++;
    if (load_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_load_cnt: got %0d expected 0", load_cnt);
    end
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign);
    end
    rst = 1'b0; ena = 1'b0;
  endtask

  task automatic test_load_hold();
    ena = 1'b1; data_in = 32'h0000_00FF;
    tick();
    n_checks++;
    if (data_out !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL load_data_out: got %h expected %h", data_out, 32'h0000_00FF);
    end
    n_checks++;
    if (load_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_cnt_1: got %0d expected 1", load_cnt);
    end
    ena = 1'b0; data_in = 32'h0000_0FFF;
    tick();
    tick();
    n_checks++;
    if (data_out !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL hold_data_out: got %h expected %h", data_out, 32'h0000_00FF);
    end
    n_checks++;
    if (load_cnt !== 32'd1 || data_prev !== 32'h0) begin
      n_fail++; $display("FAIL hold_cnt_prev: got cnt %0d prev %h expected 1 / 0", load_cnt, data_prev);
    end
  endtask

  task automatic test_load_sequence();
    ena = 1'b1; data_in = 32'h0000_FFFF;
    tick();
    data_in = 32'hFFFF_FFFF;
    tick();
    ena = 1'b0;
    n_checks++;
    if (data_out !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL seq_data_out: got %h expected %h", data_out, 32'hFFFF_FFFF);
    end
    n_checks++;
    if (data_prev !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL seq_data_prev: got %h expected %h", data_prev, 32'h0000_FFFF);
    end
    n_checks++;
    if (load_cnt !== 32'd3) begin
      n_fail++; $display("FAIL seq_load_cnt: got %0d expected 3", load_cnt);
    end
  endtask

  task automatic test_equal_load();
    ena = 1'b1; data_in = 32'hFFFF_FFFF;
    tick();
    ena = 1'b0;
    n_checks++;
    if (data_prev !== 32'hFFFF_FFFF || load_cnt !== 32'd4) begin
      n_fail++; $display("FAIL equal_load: got prev %h cnt %0d expected ffffffff / 4", data_prev, load_cnt);
    end
  endtask

  task automatic test_reset_between_edges();
    rst = 1'b1;
    #3;
    n_checks++;
    if (data_out !== 32'hFFFF_FFFF || load_cnt !== 32'd4) begin
      n_fail++; $display("FAIL sync_reset_early: got out %h cnt %0d expected ffffffff / 4", data_out, load_cnt);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'h0 || load_cnt !== 32'd0) begin
      n_fail++; $display("FAIL sync_reset_edge: got out %h cnt %0d expected 0 / 0", data_out, load_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_priority();
    ena = 1'b1; data_in = 32'h0000_1234;
    tick();
    rst = 1'b1; data_in = 32'h00FF_FFFF;
    tick();
    n_checks++;
    if (data_out !== 32'h0 || data_prev !== 32'h0 || load_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_priority: got out %h prev %h cnt %0d expected 0 / 0 / 0",
                         data_out, data_prev, load_cnt);
    end
    rst = 1'b0; ena = 1'b0;
  endtask

  task automatic test_reset_toggle();
    logic [31:0] exp_out;
    ena = 1'b1; data_in = 32'hABCD_0000;
    for (int i = 0; i < 4; i++) begin
      rst = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_out = (i % 2 == 0) ? 32'h0 : 32'hABCD_0000;
      tick();
      n_checks++;
      if (data_out !== exp_out) begin
        n_fail++; $display("FAIL reset_toggle_%0d: got %h expected %h", i, data_out, exp_out);
      end
    end
    rst = 1'b0; ena = 1'b0;
  endtask

  task automatic test_mid_reset();
    ena = 1'b1; data_in = 32'h0000_0100;
    tick();
    data_in = 32'h0000_0200;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; data_in = 32'h0000_0300;
    tick();
    ena = 1'b0;
    n_checks++;
    if (data_out !== 32'h0000_0300 || data_prev !== 32'h0 || load_cnt !== 32'd1) begin
      n_fail++; $display("FAIL mid_reset: got out %h prev %h cnt %0d expected 300 / 0 / 1",
                         data_out, data_prev, load_cnt);
    end
  endtask

  task automatic test_saturation();
    ena = 1'b0;
    force dut.load_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.load_cnt_q;
    #1;
    n_checks++;
    if (load_cnt !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL sat_preset: got %h expected %h", load_cnt, 32'hFFFF_FFFE);
    end
    @(negedge clk);
    ena = 1'b1; data_in = 32'h0000_0010;
    tick();
    n_checks++;
    if (load_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_first: got %h expected %h", load_cnt, 32'hFFFF_FFFF);
    end
    data_in = 32'h0000_0014;
    tick();
    data_in = 32'h0000_0018;
    tick();
    ena = 1'b0;
    n_checks++;
    if (load_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_hold: got %h expected %h", load_cnt, 32'hFFFF_FFFF);
    end
    n_checks++;
    if (data_out !== 32'h0000_0018 || data_prev !== 32'h0000_0014) begin
      n_fail++; $display("FAIL sat_data: got out %h prev %h expected 18 / 14", data_out, data_prev);
    end
  endtask

  task automatic test_align();
    ena = 1'b1; data_in = 32'h0000_0003;
    tick();
    ena = 1'b0;
    n_checks++;
    if (data_out !== 32'h0000_0003) begin
      n_fail++; $display("FAIL align_data_out: got %h expected %h", data_out, 32'h3);
    end
`ifdef PCREG_ALIGN_CHECK_EN
    n_checks++;
    if (misalign !== 1'b1) begin
      n_fail++; $display("FAIL align_set: got %b expected 1", misalign);
    end
    tick();
    n_checks++;
    if (misalign !== 1'b1) begin
      n_fail++; $display("FAIL align_hold: got %b expected 1", misalign);
    end
    ena = 1'b1; data_in = 32'h0000_0004;
    tick();
    ena = 1'b0;
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL align_clear: got %b expected 0", misalign);
    end
    ena = 1'b1; data_in = 32'h0000_0001;
    tick();
    ena = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL align_reset: got %b expected 0", misalign);
    end
`else
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL align_disabled: got %b expected 0", misalign);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; ena = 1'b0; data_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_load_hold();
    test_load_sequence();
    test_equal_load();
    test_reset_between_edges();
    test_reset_priority();
    test_reset_toggle();
    test_mid_reset();
    test_saturation();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcreg.md
PCREG -- requirements
Module: pcreg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named rst; clk and rst are the only timing/reset inputs.
REQ-002 Parameter WIDTH, default 32: data path width in bits, legal range 8..64.
REQ-003 Parameter RESET_VALUE, default 0 (WIDTH bits): value loaded into data_out on reset.
REQ-004 Port clk  input  1: clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: synchronous active-high reset.
REQ-006 Port ena  input  1: load enable; high = capture data_in at the next rising edge.
REQ-007 Port data_in  input  WIDTH: next program-counter value.
REQ-008 Port data_out  output  WIDTH: current program-counter value, driven directly from a register.
REQ-009 Port data_prev  output  WIDTH: data_out value held before the most recent accepted load.
REQ-010 Port load_cnt  output  32: number of accepted loads since reset; saturates at 32'hFFFF_FFFF.
REQ-011 Port misalign  output  1: alignment error flag (see Configuration); constant 0 when the feature is compiled out.

Function
REQ-012 At each rising edge with rst=1, the block SHALL set data_out=RESET_VALUE, data_prev=RESET_VALUE, load_cnt=0 and misalign=0, regardless of ena and data_in.
REQ-013 At each rising edge with rst=0 and ena=1, the block SHALL set data_out=data_in, data_prev=old data_out, and load_cnt=load_cnt+1 unless already saturated.
REQ-014 At each rising edge with rst=0 and ena=0, all outputs SHALL hold their values.
REQ-015 Load latency SHALL be one cycle: data_in sampled at edge N appears on data_out immediately after edge N.
REQ-016 Loads with data_in equal to the current data_out SHALL still count as accepted, updating data_prev and load_cnt.
REQ-017 Outputs SHALL NOT depend combinationally on any input, and there SHALL be no path from data_in to data_out except through the register.
REQ-018 The block SHALL accept any WIDTH-bit value; the all-ones value SHALL load unchanged.

Reset
REQ-019 rst SHALL take priority over ena when both are high at the same edge.
REQ-020 Reset SHALL be synchronous only; asserting rst between edges SHALL NOT change any output until the next rising edge.
REQ-021 A reset asserted mid-sequence SHALL discard the load history, so data_prev and load_cnt restart from their reset values.
REQ-022 Before the first reset edge, output values are unspecified and verification SHALL NOT check them.

Configuration
REQ-023 Macro PCREG_ALIGN_CHECK_EN SHALL enable word-alignment checking.
- Defined: on an accepted load, misalign <= (data_in[1:0] != 0), and data_out stores data_in unmodified. misalign holds while ena=0 and clears on reset.
- Undefined: misalign is tied to 0 and no alignment logic is present.

Verification
REQ-024 Reset check: rst=1, ena=1, data_in=32'h0000_000F at one edge -> data_out=0, data_prev=0, load_cnt=0.
REQ-025 Load and hold:
- rst=0, ena=1, data_in=32'h0000_00FF at one edge -> data_out=32'h0000_00FF, load_cnt=1.
- Then ena=0, data_in=32'h0000_0FFF for 2 edges -> data_out stays 32'h0000_00FF.
REQ-026 Load sequence: ena=1, data_in=32'h0000_FFFF then 32'hFFFF_FFFF on consecutive edges -> data_out=32'hFFFF_FFFF, data_prev=32'h0000_FFFF.
REQ-027 Reset priority: rst=1 and ena=1 with data_in=32'h00FF_FFFF -> data_out=0; rst toggling every 20 ns with the clock period at 20 ns -> data_out alternates between 0 and the loaded value.
REQ-028 Alignment check with PCREG_ALIGN_CHECK_EN defined:
- Load 32'h0000_0003 -> misalign=1, data_out=32'h0000_0003.
- Then load 32'h0000_0004 -> misalign=0.
REQ-029 Saturation: force load_cnt=32'hFFFF_FFFE, then perform 3 loads -> load_cnt=32'hFFFF_FFFF.
